// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, class predicates, default latencies.
// Optional multiply-accumulate ops are enabled by defining MDU_MADD_EN.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MTHI    = 4'd5,
        MTLO    = 4'd6,
        MADD    = 4'd7,
        MADDU   = 4'd8
    } md_op_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // One bit per op code; a set bit marks that code as a member of the class.
`ifdef MDU_MADD_EN
    localparam logic [15:0] MULT_CLASS_MASK = 16'h0186;
`else
    localparam logic [15:0] MULT_CLASS_MASK = 16'h0006;
`endif
    localparam logic [15:0] DIV_CLASS_MASK  = 16'h0018;

    function automatic logic is_mult_class(input logic [3:0] op);
        return MULT_CLASS_MASK[op];
    endfunction

    function automatic logic is_div_class(input logic [3:0] op);
        return DIV_CLASS_MASK[op];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> MDU signal bundle; the pipeline side is master, the MDU is slave.
interface mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, d_is_md,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, d_is_md,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational result generation from latched operands: 64-bit {hi,lo} image plus divide-by-zero flag.
// The accumulate path exists only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MDU_MADD_EN
    input  logic [63:0] acc,
`endif
    output logic [63:0] result,
    output logic        div0
);

    logic        mul_signed_s;
    logic        div_signed_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] product_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] den_s;
    logic [31:0] quot_u_s;
    logic [31:0] rem_u_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Signed ops go through magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    always_comb begin
`ifdef MDU_MADD_EN
        mul_signed_s = (op == MULT) || (op == MADD);
`else
        mul_signed_s = (op == MULT);
`endif
        div_signed_s = (op == DIV);
        mul_a_s      = mul_signed_s ? {{32{a[31]}}, a} : {32'd0, a};
        mul_b_s      = mul_signed_s ? {{32{b[31]}}, b} : {32'd0, b};
        product_s    = mul_a_s * mul_b_s;
        a_neg_s      = div_signed_s && a[31];
        b_neg_s      = div_signed_s && b[31];
        abs_a_s      = a_neg_s ? (32'd0 - a) : a;
        abs_b_s      = b_neg_s ? (32'd0 - b) : b;
        den_s        = (b == 32'd0) ? 32'd1 : abs_b_s;
        quot_u_s     = abs_a_s / den_s;
        rem_u_s      = abs_a_s % den_s;
        quot_s       = (a_neg_s ^ b_neg_s) ? (32'd0 - quot_u_s) : quot_u_s;
        rem_s        = a_neg_s ? (32'd0 - rem_u_s) : rem_u_s;
        div0         = is_div_class(op) && (b == 32'd0);
        case (op)
            MULT, MULTU: result = product_s;
            DIV, DIVU:   result = {rem_s, quot_s};
`ifdef MDU_MADD_EN
            MADD, MADDU: result = acc + product_s;
`endif
            default:     result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl_chk.sv
// Simulation checker for the MDU: a new operation must never be presented while one is running.
module mdu_ctrl_chk (
    input logic clk,
    input logic reset_n,
    input logic start,
    input logic busy
);

    // The pipeline's stall is expected to keep start low while busy.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(start && busy)) else $error("mdu: start asserted while busy");
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: fixed-latency sequencing, HI/LO ownership and D-stage stall request.
// Define MDU_MADD_EN to accept MADD/MADDU.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic  clk,
    input  logic  reset_n,
    mdu_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [4:0] MULT_LAT = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LAT  = 5'(DIV_CYCLES);

    logic [0:0]  state_r;
    logic [4:0]  cnt_r;
    logic [3:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        md_class_s;
    logic        accept_s;
    logic [63:0] result_s;
    logic        div0_s;

    mdu_arith u_arith (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
`ifdef MDU_MADD_EN
        .acc    ({hi_r, lo_r}),
`endif
        .result (result_s),
        .div0   (div0_s)
    );

    // Start decode and the combinational stall seen by D-stage hazard logic.
    always_comb begin
        md_class_s = is_mult_class(bus.op) || is_div_class(bus.op);
        accept_s   = bus.start && (state_r == ST_IDLE) && md_class_s;
        bus.stall  = bus.d_is_md && ((bus.start && md_class_s) || busy_r);
    end

    // Sequencer: operand latch, down-counter, HI/LO commit and single-cycle moves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 5'd0;
            op_r    <= 4'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        op_r    <= bus.op;
                        a_r     <= bus.rs_val;
                        b_r     <= bus.rt_val;
                        cnt_r   <= is_div_class(bus.op) ? DIV_LAT : MULT_LAT;
                    end else if (bus.start && (bus.op == MTHI)) begin
                        hi_r <= bus.rs_val;
                    end else if (bus.start && (bus.op == MTLO)) begin
                        lo_r <= bus.rs_val;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == 5'd1) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= 5'd0;
                        // A zero divisor still burns the full latency but leaves HI/LO alone.
                        if (!div0_s) begin
                            hi_r <= result_s[63:32];
                            lo_r <= result_s[31:0];
                        end
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= 5'd0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases followed by randomized ops against an arithmetic model.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_if bus ();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    mdu_ctrl_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (bus.start),
        .busy    (bus.busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_md(input logic [3:0] o);
`ifdef MDU_MADD_EN
        return o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
`else
        return o inside {4'd1, 4'd2, 4'd3, 4'd4};
`endif
    endfunction

    function automatic int model_lat(input logic [3:0] o);
        if (!model_md(o)) return 0;
        return (o == 4'd3 || o == 4'd4) ? DC : MC;
    endfunction

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          q;
        longint          r;
        case (o)
            4'd1: return 64'(sa * sb);
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return hl;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return hl;
                return {a % b, a / b};
            end
            4'd5: return {a, hl[31:0]};
            4'd6: return {hl[63:32], a};
`ifdef MDU_MADD_EN
            4'd7: return hl + 64'(sa * sb);
            4'd8: return hl + ua * ub;
`endif
            default: return hl;
        endcase
    endfunction

    // Issue one op at cycle t (called 1ns after a rising edge) and follow it to completion.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic dmd);
        int          n = model_lat(o);
        logic [63:0] exp = model(o, a, b, {m_hi, m_lo});
        bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.d_is_md = dmd;
        #1;
        chk("stall_t", 32'(bus.stall), 32'(dmd && model_md(o)));
        chk("busy_t", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        #1;
        for (int k = 1; k <= n; k++) begin
            chk("busy_run", 32'(bus.busy), 32'd1);
            chk("stall_run", 32'(bus.stall), 32'(dmd));
            chk("hi_hold", bus.hi, m_hi);
            chk("lo_hold", bus.lo, m_lo);
            @(posedge clk); #2;
        end
        chk("busy_done", 32'(bus.busy), 32'd0);
        chk("stall_done", 32'(bus.stall), 32'd0);
        chk("hi_res", bus.hi, exp[63:32]);
        chk("lo_res", bus.lo, exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        bus.d_is_md = 1'b0;
    endtask

    initial begin
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        bus.start = 1'b0; bus.op = 4'd0; bus.rs_val = 32'd0; bus.rt_val = 32'd0; bus.d_is_md = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        do_op(MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFFA);
        do_op(DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        do_op(DIVU, 32'd7, 32'd2, 1'b1);
        chk("divu_hi", bus.hi, 32'd1);
        chk("divu_lo", bus.lo, 32'd3);
        do_op(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("divovf_hi", bus.hi, 32'd0);
        chk("divovf_lo", bus.lo, 32'h80000000);
        do_op(MTHI, 32'h11, 32'd0, 1'b1);
        do_op(MTLO, 32'h22, 32'd0, 1'b0);
        do_op(DIV, 32'd5, 32'd0, 1'b1);
        chk("div0_hi", bus.hi, 32'h11);
        chk("div0_lo", bus.lo, 32'h22);
        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("multu_hi", bus.hi, 32'hFFFFFFFE);
        chk("multu_lo", bus.lo, 32'h00000001);
        do_op(4'd15, 32'h1234, 32'h5678, 1'b1);
`ifdef MDU_MADD_EN
        do_op(MTHI, 32'd0, 32'd0, 1'b0);
        do_op(MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
        do_op(MADDU, 32'd1, 32'd1, 1'b1);
        chk("maddu_hi", bus.hi, 32'd1);
        chk("maddu_lo", bus.lo, 32'd0);
`else
        do_op(MADDU, 32'd1, 32'd1, 1'b1);
`endif

        // Reset in the middle of a divide discards it.
        do_op(MTHI, 32'hAAAA, 32'd0, 1'b0);
        bus.start = 1'b1; bus.op = DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_hi", bus.hi, 32'd0);
        chk("rstmid_lo", bus.lo, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (12) @(posedge clk);
        #1;
        chk("rstmid_nobusy", 32'(bus.busy), 32'd0);
        chk("rstmid_nocommit_hi", bus.hi, 32'd0);
        chk("rstmid_nocommit_lo", bus.lo, 32'd0);

        for (int i = 0; i < 24; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            do_op(o, a, b, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
